// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state encoding and Booth recoding constants for booth_seq_mult.
//   state_t    : ST_IDLE waits for start, ST_CALC runs one add/sub-and-shift step per clock
//   BOOTH_*    : decisions taken from the {Q[0], Q_1} bit pair
package booth_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    localparam logic [1:0] BOOTH_NOP    = 2'b00;
    localparam logic [1:0] BOOTH_NOP_HI = 2'b11;
    localparam logic [1:0] BOOTH_ADD    = 2'b01;
    localparam logic [1:0] BOOTH_SUB    = 2'b10;

endpackage

// File: rtl/booth_ff_reg.sv
// booth_ff_reg: parametrised register, asynchronous active-low clear, synchronous load enable.
//   clk   in  1      clock
//   rst_n in  1      asynchronous reset to 0, active-low
//   en    in  1      load d on the rising edge when high
//   d     in  WIDTH  next value
//   q     out WIDTH  stored value
module booth_ff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock.
//   clk          in  1        clock
//   rst_n        in  1        asynchronous reset, active-low; aborts any operation
//   start        in  1        request, only honoured while idle
//   multiplicand in  WIDTH    operand M, captured when start is accepted
//   multiplier   in  WIDTH    operand Q, captured when start is accepted
//   busy         out 1        high while a multiplication is in progress
//   done         out 1        one-cycle pulse when product is updated
//   product      out 2*WIDTH  last result, held until the next done
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // One guard bit lets -2^(WIDTH-1) and unsigned full-scale operands run through
    // a signed Booth datapath without overflow.
    localparam int IW    = WIDTH + 1;
    localparam int ITER  = WIDTH + 1;
    localparam int CNT_W = $clog2(ITER + 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   count;
    logic [IW-1:0]      a, q, m;
    logic [0:0]         q_1;
    logic [IW-1:0]      ext_mc, ext_mp;
    logic [IW-1:0]      a_sum, a_sh, q_sh, a_d, q_d;
    logic [0:0]         q1_d;
    logic [1:0]         booth;
    logic               accept, calc, last;

    assign accept = (state == ST_IDLE) && start;
    assign calc   = (state == ST_CALC);
    assign last   = calc && (count == CNT_W'(1));
    assign busy   = calc;

    assign ext_mc = (SIGNED != 0) ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    assign ext_mp = (SIGNED != 0) ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};

    assign booth = {q[0], q_1[0]};

    always_comb begin
        a_sum = (booth == BOOTH_SUB) ? a - m :
                (booth == BOOTH_ADD) ? a + m : a;
        // arithmetic right shift of {A', Q, Q_1}
        a_sh  = {a_sum[IW-1], a_sum[IW-1:1]};
        q_sh  = {a_sum[0], q[IW-1:1]};
        a_d   = accept ? '0 : a_sh;
        q_d   = accept ? ext_mp : q_sh;
        q1_d  = accept ? 1'b0 : q[0];
    end

    always_comb begin
        state_d = state;
        if (accept) state_d = ST_CALC;
        else if (last) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            count <= accept ? CNT_W'(ITER) : calc ? count - 1'b1 : count;
            done  <= last;
        end
    end

    booth_ff_reg #(.WIDTH(IW)) u_a (
        .clk(clk), .rst_n(rst_n), .en(accept | calc), .d(a_d), .q(a)
    );

    booth_ff_reg #(.WIDTH(IW)) u_q (
        .clk(clk), .rst_n(rst_n), .en(accept | calc), .d(q_d), .q(q)
    );

    booth_ff_reg #(.WIDTH(1)) u_q_1 (
        .clk(clk), .rst_n(rst_n), .en(accept | calc), .d(q1_d), .q(q_1)
    );

    booth_ff_reg #(.WIDTH(IW)) u_m (
        .clk(clk), .rst_n(rst_n), .en(accept), .d(ext_mc), .q(m)
    );

    // Low 2*WIDTH bits of the final shifted {A, Q}; the guard bits drop out.
    booth_ff_reg #(.WIDTH(2*WIDTH)) u_product (
        .clk(clk), .rst_n(rst_n), .en(last), .d({a_sh[WIDTH-2:0], q_sh}), .q(product)
    );

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed and reference-checked stimulus for signed/unsigned 8-bit and signed 16-bit multipliers.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] mc = '0;
    logic [15:0] mp = '0;

    logic        busy_s8, done_s8, busy_u8, done_u8, busy_s16, done_s16;
    logic [15:0] prod_s8, prod_u8;
    logic [31:0] prod_s16;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(8), .SIGNED(1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mc[7:0]), .multiplier(mp[7:0]),
        .busy(busy_s8), .done(done_s8), .product(prod_s8)
    );

    booth_seq_mult #(.WIDTH(8), .SIGNED(0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mc[7:0]), .multiplier(mp[7:0]),
        .busy(busy_u8), .done(done_u8), .product(prod_u8)
    );

    booth_seq_mult #(.WIDTH(16), .SIGNED(1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mc), .multiplier(mp),
        .busy(busy_s16), .done(done_s16), .product(prod_s16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Runs one operation on all three multipliers and checks latency, busy length,
    // done width and products over a 20-cycle window after the accept edge.
    task automatic go(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] e_s8, input logic [15:0] e_u8, input logic [31:0] e_s16);
        int ls8 = -1, lu8 = -1, l16 = -1;
        int ds8 = 0, du8 = 0, d16 = 0;
        int bs8 = 0, bu8 = 0, b16 = 0;
        @(negedge clk);
        mc = a;
        mp = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_s8) begin ds8++; if (ls8 < 0) ls8 = i; end
            if (done_u8) begin du8++; if (lu8 < 0) lu8 = i; end
            if (done_s16) begin d16++; if (l16 < 0) l16 = i; end
            bs8 += int'(busy_s8);
            bu8 += int'(busy_u8);
            b16 += int'(busy_s16);
            @(posedge clk);
            #1;
        end
        chk({tag, "_lat_s8"}, ls8, 9);
        chk({tag, "_lat_u8"}, lu8, 9);
        chk({tag, "_lat_s16"}, l16, 17);
        chk({tag, "_done_w_s8"}, ds8, 1);
        chk({tag, "_done_w_u8"}, du8, 1);
        chk({tag, "_done_w_s16"}, d16, 1);
        chk({tag, "_busy_s8"}, bs8, 9);
        chk({tag, "_busy_u8"}, bu8, 9);
        chk({tag, "_busy_s16"}, b16, 17);
        chk({tag, "_prod_s8"}, {16'h0, prod_s8}, {16'h0, e_s8});
        chk({tag, "_prod_u8"}, {16'h0, prod_u8}, {16'h0, e_u8});
        chk({tag, "_prod_s16"}, prod_s16, e_s16);
    endtask

    // Waits for done_s8, returning the edge number counted from the accept edge (base).
    task automatic wait8(input int base, output int cyc);
        cyc = -1;
        for (int i = base + 1; i <= base + 30; i++) begin
            @(posedge clk);
            #1;
            if (done_s8) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc, n_done, x, y;
        logic [15:0] ra, rb, e8s, e8u;
        logic [31:0] e16;

        #2;
        chk("rst_busy", {29'h0, busy_s8, busy_u8, busy_s16}, 32'h0);
        chk("rst_done", {29'h0, done_s8, done_u8, done_s16}, 32'h0);
        chk("rst_prod", prod_s16 | {16'h0, prod_s8 | prod_u8}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        go("s3xm4",   16'h0003, 16'hFFFC, 16'hFFF4, 16'h02F4, 32'hFFFF_FFF4);
        go("m128sq",  16'hFF80, 16'hFF80, 16'h4000, 16'h4000, 32'h0000_4000);
        go("m128x127",16'hFF80, 16'h007F, 16'hC080, 16'h3F80, 32'hFFFF_C080);
        go("ff_sq",   16'h00FF, 16'h00FF, 16'h0001, 16'hFE01, 32'h0000_FE01);
        go("zero",    16'h0000, 16'h00C8, 16'h0000, 16'h0000, 32'h0000_0000);
        go("min16sq", 16'h8000, 16'h8000, 16'h0000, 16'h0000, 32'h4000_0000);
        go("max_min", 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 32'hC000_8000);

        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            x = $signed(ra[7:0]);
            y = $signed(rb[7:0]);
            e8s = 16'(x * y);
            x = int'(ra[7:0]);
            y = int'(rb[7:0]);
            e8u = 16'(x * y);
            x = $signed(ra);
            y = $signed(rb);
            e16 = 32'(x * y);
            go("rnd", ra, rb, e8s, e8u, e16);
        end

        // start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        mc = 16'd5;
        mp = 16'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mc = 16'd7;
        mp = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        mc = '0;
        mp = '0;
        wait8(4, cyc);
        chk("busy_ign_lat", cyc, 9);
        chk("busy_ign_prod", {16'h0, prod_s8}, 32'h001E);
        start = 1'b1;
        mc = 16'd7;
        mp = 16'd7;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_hold", {16'h0, prod_s8}, 32'h001E);
        chk("b2b_busy", {31'h0, busy_s8}, 32'h1);
        wait8(0, cyc);
        chk("b2b_lat", cyc, 9);
        chk("b2b_prod", {16'h0, prod_s8}, 32'h0031);
        repeat (20) @(posedge clk);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        mc = 16'h0003;
        mp = 16'hFFFC;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {29'h0, busy_s8, busy_u8, busy_s16}, 32'h0);
        chk("abort_done", {29'h0, done_s8, done_u8, done_s16}, 32'h0);
        chk("abort_prod_s8", {16'h0, prod_s8}, 32'h0);
        chk("abort_prod_s16", prod_s16, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            n_done += int'(done_s8 | done_u8 | done_s16 | busy_s8 | busy_s16);
        end
        chk("abort_quiet", n_done, 0);

        go("post_rst", 16'h0005, 16'h0006, 16'h001E, 16'h001E, 32'h0000_001E);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
